mem_responder: RTL and testbench

//  Memory-side responder for the CPU/cache/TLB memory port: accepts mem_access

---
 rtl/mem_responder_if.sv | 38 +++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory port between an initiator (CPU/cache/TLB) and mem_responder.
// Optional macro: MEM_OOR_EN adds the mem_err out-of-range flag.
//
// Handshake: the initiator raises mem_access together with mem_a, mem_write
// and mem_st_data, and holds mem_access until it sees mem_ready. The responder
// takes the request in an idle cycle, keeps mem_busy high while the request is
// in flight, and finishes with a single-cycle mem_ready pulse. Read data sits
// on mem_data in that cycle and stays there until the next read completes.
// The initiator must drop mem_access after mem_ready unless it wants the
// request taken again.
interface mem_responder_if;
  logic [31:0] mem_a;
  logic [31:0] mem_st_data;
  logic        mem_access;
  logic        mem_write;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        mem_busy;
`ifdef MEM_OOR_EN
  logic        mem_err;
`endif

  modport master (
    output mem_a, mem_st_data, mem_access, mem_write,
`ifdef MEM_OOR_EN
    input  mem_err,
`endif
    input  mem_data, mem_ready, mem_busy
  );

  modport slave (
    input  mem_a, mem_st_data, mem_access, mem_write,
`ifdef MEM_OOR_EN
    output mem_err,
`endif
    output mem_data, mem_ready, mem_busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one-word read/write requests, waits LATENCY
// cycles, then completes with a one-cycle mem_ready pulse.
// Optional macro: MEM_OOR_EN flags addresses above the array (mem_err),
// suppresses such writes and returns 32'hDEADBEEF for such reads. Without it,
// upper address bits are ignored and addresses wrap.
module mem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  mem_responder_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          accept;
  logic          commit;

  logic [AW-1:0] lat_addr;
  logic          lat_write;
  logic [31:0]   lat_data;
  logic          lat_oor;
  logic [31:0]   rd_data;

  logic [31:0]   ram [0:(1<<AW)-1];

  assign accept = (state == IDLE) && bus.mem_access;
  // The BUSY->RESP edge is where the array is written or read.
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // State and wait counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> BUSY (LATENCY cycles) -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.mem_access) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture; later input changes are invisible to the in-flight request.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_data  <= '0;
    end else if (accept) begin
      lat_addr  <= bus.mem_a[AW+1:2];
      lat_write <= bus.mem_write;
      lat_data  <= bus.mem_st_data;
    end
  end

`ifdef MEM_OOR_EN
  // Out-of-range flag captured with the request.
  always_ff @(posedge clock) begin
    if (reset)       lat_oor <= 1'b0;
    else if (accept) lat_oor <= (bus.mem_a[31:AW+2] != '0);
  end

  assign bus.mem_err = (state == RESP) && lat_oor;
`else
  assign lat_oor = 1'b0;
`endif

  // Word array; contents survive reset, and a reset in BUSY cancels the write.
  always_ff @(posedge clock) begin
    if (!reset && commit && lat_write && !lat_oor) begin
      ram[lat_addr] <= lat_data;
    end
  end

  // Read data register: loaded only when a read completes, held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (commit && !lat_write) begin
      rd_data <= lat_oor ? 32'hDEAD_BEEF : ram[lat_addr];
    end
  end

  assign bus.mem_data  = rd_data;
  assign bus.mem_ready = (state == RESP);
  assign bus.mem_busy  = (state != IDLE);
  assign dbg_state     = state;

  // Byte-offset bits (and, in the wrapping build, upper bits) are not used.
  logic unused_addr_bits;
`ifdef MEM_OOR_EN
  assign unused_addr_bits = ^bus.mem_a[1:0];
`else
  assign unused_addr_bits = ^{bus.mem_a[31:AW+2], bus.mem_a[1:0]};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (AW=10, LATENCY=4).
// Optional macro: MEM_OOR_EN selects the out-of-range checks.
module tb_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  mem_responder_if bus();

  mem_responder #(.AW(AW), .LATENCY(LAT)) dut (
    .clock     (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request at cycle 0 and watches 12 cycles. drop_at >= 0 drops
  // mem_access (and scrambles the other inputs) in that cycle; otherwise the
  // request is held until mem_ready is seen.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int drop_at,
                       output int rdy_cyc, output int rdy_cnt, output int busy_err,
                       output logic [31:0] rdy_data, output logic rdy_err);
    @(posedge clk); #1;
    bus.mem_access  = 1'b1;
    bus.mem_write   = wr;
    bus.mem_a       = a;
    bus.mem_st_data = d;
    rdy_cyc  = -1;
    rdy_cnt  = 0;
    busy_err = 0;
    rdy_data = 'x;
    rdy_err  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc  = k;
          rdy_data = bus.mem_data;
`ifdef MEM_OOR_EN
          rdy_err  = bus.mem_err;
`endif
        end
      end
      if (bus.mem_busy !== ((k >= 1) && (k <= LAT + 1))) busy_err++;
      if (k == drop_at || bus.mem_ready === 1'b1) begin
        bus.mem_access  = 1'b0;
        bus.mem_write   = ~wr;
        bus.mem_a       = 32'h0000_0000;
        bus.mem_st_data = 32'hFFFF_FFFF;
      end
    end
  endtask

  // Read with the expected word queued on the scoreboard first.
  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int rc, rn, be;
    logic [31:0] rd;
    logic re;
    exp_q.push_back(exp);
    issue(1'b0, a, 32'h0, -1, rc, rn, be, rd, re);
    check({tag, "_rdy_cyc"}, rc, LAT + 1);
    check({tag, "_data"}, rd, exp_q.pop_front());
  endtask

  task automatic write_do(input logic [31:0] a, input logic [31:0] d);
    int rc, rn, be;
    logic [31:0] rd;
    logic re;
    issue(1'b1, a, d, -1, rc, rn, be, rd, re);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rc, rn, be, r1, r2;
    logic [31:0] rd, d2;
    logic re;

    bus.mem_access  = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_a       = '0;
    bus.mem_st_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.mem_ready, 0);
    check("rst_busy",  bus.mem_busy, 0);
    check("rst_data",  bus.mem_data, 0);
    check("rst_state", dbg_state, 0);
`ifdef MEM_OOR_EN
    check("rst_err",   bus.mem_err, 0);
`endif
    reset = 1'b0;

    // T1: write 0x40, ready in cycle 5 only, busy 1..5, data untouched
    issue(1'b1, 32'h40, 32'h1234_5678, -1, rc, rn, be, rd, re);
    check("t1_rdy_cyc", rc, 5);
    check("t1_rdy_cnt", rn, 1);
    check("t1_busy",    be, 0);
    check("t1_data",    bus.mem_data, 0);

    // T2: read back, data held, write leaves data alone
    read_chk("t2_rd40", 32'h40, 32'h1234_5678);
    check("t2_held", bus.mem_data, 32'h1234_5678);
    issue(1'b1, 32'h44, 32'h9ABC_DEF0, -1, rc, rn, be, rd, re);
    check("t2_wr_rdy_cyc", rc, 5);
    check("t2_wr_keep", bus.mem_data, 32'h1234_5678);

    // T3: drop access in cycle 2 of a write
    issue(1'b1, 32'h80, 32'hA5A5_A5A5, 2, rc, rn, be, rd, re);
    check("t3_rdy_cyc", rc, 5);
    check("t3_rdy_cnt", rn, 1);
    check("t3_busy",    be, 0);
    read_chk("t3_rd80", 32'h80, 32'hA5A5_A5A5);

    // T4: reset in BUSY cycle 3 aborts a write
    write_do(32'hC0, 32'h0BAD_F00D);
    @(posedge clk); #1;
    bus.mem_access  = 1'b1;
    bus.mem_write   = 1'b1;
    bus.mem_a       = 32'hC0;
    bus.mem_st_data = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_access = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t4_busy_c3", bus.mem_busy, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_rst_ready", bus.mem_ready, 0);
    check("t4_rst_busy",  bus.mem_busy, 0);
    check("t4_rst_data",  bus.mem_data, 0);
    check("t4_rst_state", dbg_state, 0);
    rn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) rn++;
    end
    check("t4_no_ready", rn, 0);
    read_chk("t4_rdC0", 32'hC0, 32'h0BAD_F00D);

    // T5: access held across RESP with a new address 0x44
    @(posedge clk); #1;
    bus.mem_access = 1'b1;
    bus.mem_write  = 1'b0;
    bus.mem_a      = 32'h40;
    r1 = -1;
    r2 = -1;
    rd = 'x;
    d2 = 'x;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) begin
        if (r1 < 0) begin
          r1 = k;
          rd = bus.mem_data;
          bus.mem_a = 32'h44;
        end else if (r2 < 0) begin
          r2 = k;
          d2 = bus.mem_data;
          bus.mem_access = 1'b0;
        end
      end
      if (k == 6) check("t5_idle_c6", bus.mem_busy, 0);
    end
    check("t5_rdy1",  r1, 5);
    check("t5_gap",   r2 - r1, 6);
    check("t5_data1", rd, 32'h1234_5678);
    check("t5_data2", d2, 32'h9ABC_DEF0);

    // Top word of the array
    write_do(32'hFFC, 32'hCAFE_F00D);
    read_chk("top_word", 32'hFFC, 32'hCAFE_F00D);

    // T6: upper address bits
    write_do(32'h0, 32'h00C0_FFEE);
`ifdef MEM_OOR_EN
    issue(1'b0, 32'h0000_1000, 32'h0, -1, rc, rn, be, rd, re);
    check("t6_oor_rdy_cyc", rc, 5);
    check("t6_oor_data", rd, 32'hDEAD_BEEF);
    check("t6_oor_err", re, 1);
    issue(1'b1, 32'h0000_1000, 32'h5555_AAAA, -1, rc, rn, be, rd, re);
    check("t6_oor_wr_err", re, 1);
    issue(1'b0, 32'h0, 32'h0, -1, rc, rn, be, rd, re);
    check("t6_w0_data", rd, 32'h00C0_FFEE);
    check("t6_w0_err", re, 0);
`else
    write_do(32'h0000_1000, 32'h55AA_55AA);
    read_chk("t6_alias", 32'h0, 32'h55AA_55AA);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
